// File: rtl/serial_subtractor_if.sv
// Valid/ready operand and result bundle for serial_subtractor.
// The master side owns the operands and out_ready; the slave side is the subtractor.
interface serial_subtractor_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] minuend;
    logic [WIDTH-1:0] subtrahend;
    logic             carry_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] difference;
    logic             borrow_out;
    logic             overflow;

    modport master (
        output in_valid,
        output minuend,
        output subtrahend,
        output carry_in,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  difference,
        input  borrow_out,
        input  overflow
    );

    modport slave (
        input  in_valid,
        input  minuend,
        input  subtrahend,
        input  carry_in,
        input  out_ready,
        output in_ready,
        output out_valid,
        output difference,
        output borrow_out,
        output overflow
    );
endinterface

// File: rtl/serial_subtractor.sv
// Multi-cycle subtractor: minuend - subtrahend - carry_in, DIGIT bits per clock,
// with the borrow rippled through a register between slices.
module serial_subtractor #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 4
) (
    input logic                clk,
    input logic                rst,
    serial_subtractor_if.slave bus
);
    localparam int unsigned STEPS     = (DIGIT > 0) ? WIDTH / DIGIT : 1;
    localparam int unsigned STEP_W    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);

    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $error("serial_subtractor: WIDTH must be a nonzero multiple of DIGIT");
    end

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [WIDTH-1:0]  a_q, b_q;
    logic [WIDTH-1:0]  part_q, part_d;
    logic              borrow_q;
    logic [WIDTH-1:0]  diff_q;
    logic              bout_q;
    logic              ovf_q, ovf_d;

    logic              accept;
    logic              last;
    int unsigned       base;
    logic [DIGIT-1:0]  a_slice, b_slice;
    logic [DIGIT:0]    slice_res;
    logic              slice_borrow;

    assign accept = (state_q == StIdle) && bus.in_valid;
    assign last   = (step_q == LAST_STEP);

    // ---------------------------------------------------------------- state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.in_valid) state_d = StRun;
            StRun:   if (last)         state_d = StDone;
            StDone:  if (bus.out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // ---------------------------------------------------------------- outputs
    always_comb begin
        bus.in_ready  = (state_q == StIdle);
        bus.out_valid = (state_q == StDone);
    end

    assign bus.difference = diff_q;
    assign bus.borrow_out = bout_q;
    assign bus.overflow   = ovf_q;

    // ---------------------------------------------------------------- slice datapath
    // A (DIGIT+1)-bit difference goes negative exactly when the slice borrows,
    // so its top bit is the borrow out.
    always_comb begin
        base         = 32'(step_q) * DIGIT;
        a_slice      = a_q[base +: DIGIT];
        b_slice      = b_q[base +: DIGIT];
        slice_res    = {1'b0, a_slice} - {1'b0, b_slice} - {{DIGIT{1'b0}}, borrow_q};
        slice_borrow = slice_res[DIGIT];
        part_d       = part_q;
        part_d[base +: DIGIT] = slice_res[DIGIT-1:0];
        ovf_d        = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (part_d[WIDTH-1] != a_q[WIDTH-1]);
        step_d       = last ? '0 : step_q + STEP_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            part_q   <= '0;
            borrow_q <= 1'b0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (accept) begin
            a_q      <= bus.minuend;
            b_q      <= bus.subtrahend;
            borrow_q <= bus.carry_in;
            step_q   <= '0;
            part_q   <= '0;
        end else if (state_q == StRun) begin
            part_q   <= part_d;
            borrow_q <= slice_borrow;
            step_q   <= step_d;
            // Result registers only move on the final slice so they hold during RUN.
            if (last) begin
                diff_q <= part_d;
                bout_q <= slice_borrow;
                ovf_q  <= ovf_d;
            end
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: a 16-bit/4-digit instance and a
// 1-bit/1-digit instance, checked against plain-arithmetic expectations.
module tb_serial_subtractor;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    serial_subtractor_if #(.WIDTH(16)) bus16 ();
    serial_subtractor_if #(.WIDTH(1))  bus1 ();

    serial_subtractor #(.WIDTH(16), .DIGIT(4)) u_dut16 (
        .clk (clk),
        .rst (rst),
        .bus (bus16)
    );

    serial_subtractor #(.WIDTH(1), .DIGIT(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached (checks=%0d)", n_checks);
        $fatal(1, "watchdog");
    end

    // Reference: whole-word integer subtraction, no slicing.
    function automatic logic [17:0] model16(input logic [15:0] a, input logic [15:0] b,
                                            input logic c);
        int          t;
        logic [15:0] d;
        logic        bo;
        logic        ov;
        t  = int'(a) - int'(b) - int'(c);
        d  = t[15:0];
        bo = (t < 0);
        ov = (a[15] != b[15]) && (d[15] != a[15]);
        return {d, bo, ov};
    endfunction

    task automatic do_op16(input logic [15:0] a, input logic [15:0] b, input logic c,
                           output logic [15:0] d, output logic bo, output logic ov,
                           output int lat);
        int waited;
        waited = 0;
        @(negedge clk);
        while (bus16.in_ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (bus16.in_ready !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept16_timeout in_ready=%b want 1", bus16.in_ready);
        end
        bus16.in_valid   = 1'b1;
        bus16.minuend    = a;
        bus16.subtrahend = b;
        bus16.carry_in   = c;
        @(posedge clk);
        #1 bus16.in_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (bus16.out_valid !== 1'b1 && lat < 50);
        d  = bus16.difference;
        bo = bus16.borrow_out;
        ov = bus16.overflow;
    endtask

    task automatic do_op1(input logic a, input logic b, input logic c,
                          output logic d, output logic bo, output logic ov, output int lat);
        int waited;
        waited = 0;
        @(negedge clk);
        while (bus1.in_ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (bus1.in_ready !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept1_timeout in_ready=%b want 1", bus1.in_ready);
        end
        bus1.in_valid   = 1'b1;
        bus1.minuend    = a;
        bus1.subtrahend = b;
        bus1.carry_in   = c;
        @(posedge clk);
        #1 bus1.in_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (bus1.out_valid !== 1'b1 && lat < 50);
        d  = bus1.difference;
        bo = bus1.borrow_out;
        ov = bus1.overflow;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({bus16.in_ready, bus16.out_valid, bus16.difference, bus16.borrow_out,
             bus16.overflow} !== {1'b1, 1'b0, 16'h0000, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset16 rdy=%b vld=%b diff=%h bo=%b ov=%b want 1 0 0000 0 0",
                     bus16.in_ready, bus16.out_valid, bus16.difference, bus16.borrow_out,
                     bus16.overflow);
        end
        n_checks++;
        if ({bus1.in_ready, bus1.out_valid, bus1.difference, bus1.borrow_out,
             bus1.overflow} !== 5'b10000) begin
            n_fail++;
            $display("FAIL reset1 got %b want 10000", {bus1.in_ready, bus1.out_valid,
                     bus1.difference, bus1.borrow_out, bus1.overflow});
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [15:0] d;
        logic        bo, ov;
        int          lat;
        do_op16(16'h1234, 16'h0234, 1'b0, d, bo, ov, lat);
        n_checks++;
        if ({d, bo, ov} !== {16'h1000, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL basic_result got %h/%b/%b want 1000/0/0", d, bo, ov);
        end
        n_checks++;
        if (lat != 4) begin
            n_fail++;
            $display("FAIL basic_latency got %0d want 4", lat);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if ({bus16.out_valid, bus16.in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL basic_one_cycle_valid vld/rdy got %b%b want 01",
                     bus16.out_valid, bus16.in_ready);
        end
    endtask

    task automatic test_borrow_ripple();
        logic [15:0] d;
        logic        bo, ov;
        int          lat;
        do_op16(16'h0000, 16'h0001, 1'b0, d, bo, ov, lat);
        n_checks++;
        if ({d, bo, ov} !== {16'hFFFF, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL ripple_0_minus_1 got %h/%b/%b want ffff/1/0", d, bo, ov);
        end
        do_op16(16'h0005, 16'h0005, 1'b1, d, bo, ov, lat);
        n_checks++;
        if ({d, bo} !== {16'hFFFF, 1'b1}) begin
            n_fail++;
            $display("FAIL ripple_cin got %h/%b want ffff/1", d, bo);
        end
    endtask

    task automatic test_overflow();
        logic [15:0] d;
        logic        bo, ov;
        int          lat;
        do_op16(16'h8000, 16'h0001, 1'b0, d, bo, ov, lat);
        n_checks++;
        if ({d, bo, ov} !== {16'h7FFF, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL ovf_8000_1 got %h/%b/%b want 7fff/0/1", d, bo, ov);
        end
        do_op16(16'h7FFF, 16'hFFFF, 1'b0, d, bo, ov, lat);
        n_checks++;
        if ({d, bo, ov} !== {16'h8000, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL ovf_7fff_ffff got %h/%b/%b want 8000/1/1", d, bo, ov);
        end
        do_op16(16'h7FFF, 16'h0001, 1'b0, d, bo, ov, lat);
        n_checks++;
        if ({d, ov} !== {16'h7FFE, 1'b0}) begin
            n_fail++;
            $display("FAIL ovf_7fff_1 got %h/%b want 7ffe/0", d, ov);
        end
    endtask

    task automatic test_random();
        logic [15:0] a, b, d;
        logic        c, bo, ov;
        logic [17:0] exp;
        int          lat;
        for (int i = 0; i < 40; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            c = 1'($urandom);
            if ($urandom_range(0, 4) == 0) a = (i % 2 == 0) ? 16'h8000 : 16'h7FFF;
            if ($urandom_range(0, 4) == 0) b = a;
            exp = model16(a, b, c);
            do_op16(a, b, c, d, bo, ov, lat);
            n_checks++;
            if ({d, bo, ov} !== exp) begin
                n_fail++;
                $display("FAIL random[%0d] %h-%h-%b got %h/%b/%b want %h/%b/%b", i, a, b, c,
                         d, bo, ov, exp[17:2], exp[1], exp[0]);
            end
            n_checks++;
            if (lat != 4) begin
                n_fail++;
                $display("FAIL random_latency[%0d] got %0d want 4", i, lat);
            end
        end
    endtask

    task automatic test_width1();
        logic [1:0] req[8];
        logic       d, bo, ov, ov_exp;
        logic [2:0] v;
        int         lat;
        req = '{2'b00, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00, 2'b00, 2'b11};
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            ov_exp = (v[2] != v[1]) && (req[i][0] != v[2]);
            do_op1(v[2], v[1], v[0], d, bo, ov, lat);
            n_checks++;
            if ({bo, d, ov} !== {req[i], ov_exp}) begin
                n_fail++;
                $display("FAIL width1[%0d] {bo,d,ov} got %b%b%b want %b%b", i, bo, d, ov,
                         req[i], ov_exp);
            end
            n_checks++;
            if (lat != 1) begin
                n_fail++;
                $display("FAIL width1_latency[%0d] got %0d want 1", i, lat);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] d;
        logic        bo, ov;
        int          lat;
        bus16.out_ready = 1'b0;
        do_op16(16'h4321, 16'h0321, 1'b0, d, bo, ov, lat);
        n_checks++;
        if ({d, bo, ov} !== {16'h4000, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL bp_result got %h/%b/%b want 4000/0/0", d, bo, ov);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 1) begin
                bus16.in_valid   = 1'b1;
                bus16.minuend    = 16'hFFFF;
                bus16.subtrahend = 16'h0001;
                bus16.carry_in   = 1'b0;
            end else begin
                bus16.in_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            n_checks++;
            if ({bus16.out_valid, bus16.in_ready, bus16.difference, bus16.borrow_out,
                 bus16.overflow} !== {1'b1, 1'b0, 16'h4000, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL bp_hold[%0d] vld=%b rdy=%b diff=%h bo=%b ov=%b want 1 0 4000 0 0",
                         i, bus16.out_valid, bus16.in_ready, bus16.difference,
                         bus16.borrow_out, bus16.overflow);
            end
        end
        @(negedge clk) bus16.out_ready = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if ({bus16.out_valid, bus16.in_ready, bus16.difference} !== {1'b0, 1'b1, 16'h4000}) begin
            n_fail++;
            $display("FAIL bp_release vld=%b rdy=%b diff=%h want 0 1 4000",
                     bus16.out_valid, bus16.in_ready, bus16.difference);
        end
        do_op16(16'hFFFF, 16'h0001, 1'b0, d, bo, ov, lat);
        n_checks++;
        if ({d, bo, ov} !== {16'hFFFE, 1'b0, 1'b0} || lat != 4) begin
            n_fail++;
            $display("FAIL bp_after got %h/%b/%b lat %0d want fffe/0/0 lat 4", d, bo, ov, lat);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] d;
        logic        bo, ov;
        int          lat;
        int          waited;
        int          spurious;
        waited = 0;
        @(negedge clk);
        while (bus16.in_ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        bus16.in_valid   = 1'b1;
        bus16.minuend    = 16'h1234;
        bus16.subtrahend = 16'h1111;
        bus16.carry_in   = 1'b0;
        @(posedge clk);
        #1 bus16.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        n_checks++;
        if ({bus16.in_ready, bus16.out_valid, bus16.difference} !== {1'b0, 1'b0, 16'hFFFE}) begin
            n_fail++;
            $display("FAIL mid_run_state rdy=%b vld=%b diff=%h want 0 0 fffe",
                     bus16.in_ready, bus16.out_valid, bus16.difference);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({bus16.in_ready, bus16.out_valid, bus16.difference, bus16.borrow_out,
             bus16.overflow} !== {1'b1, 1'b0, 16'h0000, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL mid_async_reset rdy=%b vld=%b diff=%h bo=%b ov=%b want 1 0 0000 0 0",
                     bus16.in_ready, bus16.out_valid, bus16.difference, bus16.borrow_out,
                     bus16.overflow);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        spurious = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (bus16.out_valid !== 1'b0 || bus16.in_ready !== 1'b1) spurious++;
        end
        n_checks++;
        if (spurious != 0) begin
            n_fail++;
            $display("FAIL mid_abandoned spurious cycles got %0d want 0", spurious);
        end
        do_op16(16'h00FF, 16'h0F00, 1'b0, d, bo, ov, lat);
        n_checks++;
        if ({d, bo, ov} !== {16'hF1FF, 1'b1, 1'b0} || lat != 4) begin
            n_fail++;
            $display("FAIL mid_after got %h/%b/%b lat %0d want f1ff/1/0 lat 4", d, bo, ov, lat);
        end
    endtask

    initial begin
        n_checks         = 0;
        n_fail           = 0;
        bus16.in_valid   = 1'b0;
        bus16.minuend    = '0;
        bus16.subtrahend = '0;
        bus16.carry_in   = 1'b0;
        bus16.out_ready  = 1'b1;
        bus1.in_valid    = 1'b0;
        bus1.minuend     = '0;
        bus1.subtrahend  = '0;
        bus1.carry_in    = 1'b0;
        bus1.out_ready   = 1'b1;

        test_reset();
        test_basic();
        test_borrow_ripple();
        test_overflow();
        test_random();
        test_width1();
        test_backpressure();
        test_reset_mid();

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Parametrised multi-cycle subtractor. It computes `minuend - subtrahend - carry_in` over WIDTH bits, DIGIT bits per clock, with a ripple borrow register between slices. It generalises the single-bit full subtractor to arbitrary width and trades area for latency via DIGIT. It uses valid/ready handshakes on both sides, so it drops into the lab datapath between operand registers and a result consumer.

## Interface
- WIDTH, 16, operand/result width in bits; must be ≥1.
- DIGIT, 4, bits processed per cycle; WIDTH % DIGIT must be 0, otherwise elaboration fails. STEPS = WIDTH/DIGIT.
- Clocking: one clock; reset is asynchronous and active-high.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands and carry_in are valid.
- in_ready  out  1  block can accept an operation.
- minuend  in  WIDTH  unsigned / two's-complement minuend.
- subtrahend  in  WIDTH  subtrahend.
- carry_in  in  1  incoming borrow (subtracted at bit 0).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- difference  out  WIDTH  result, modulo 2^WIDTH.
- borrow_out  out  1  final borrow; 1 iff minuend < subtrahend + carry_in (unsigned).
- overflow  out  1  signed overflow.

## Operation
- States: IDLE, RUN, DONE. Counter `step` runs 0..STEPS-1. Internal registers hold the operand copies, the partial result and the borrow.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch minuend, subtrahend; borrow<=carry_in; step<=0; go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle compute slice s=step: {b, d} = A[s] - B[s] - borrow, where A[s]/B[s] are bits [s*DIGIT +: DIGIT]. This is a (DIGIT+1)-bit computation; b is the borrow out of the slice.
  - Store d in partial result slice s; borrow<=b; step<=step+1.
  - At step==STEPS-1: load difference with the completed result, borrow_out with b, and overflow; go to DONE.
- Overflow rule: (A[msb]!=B[msb]) && (difference[msb]!=A[msb]). This uses the final difference including the carry_in effect.
- DONE:
  - out_valid=1; in_ready=0.
  - On out_ready, go to IDLE.
- Output holding: difference, borrow_out and overflow hold the last completed result until the next RUN→DONE transition. They do not change during RUN.
- in_valid in RUN or DONE is ignored; no queueing.
- Reset:
  - Any state → IDLE immediately (asynchronous).
  - Output reset values: in_ready=1, out_valid=0, difference=0, borrow_out=0, overflow=0. Internal step=0, borrow=0.
  - Reset mid-RUN abandons the operation; no result is produced.
- STEPS=1 (DIGIT=WIDTH) is legal: RUN lasts one cycle.

## Timing
- Accept edge E0. RUN occupies the next STEPS edges. out_valid rises after edge E0+STEPS (latency STEPS cycles).
- With out_ready held high, out_valid is high for exactly one cycle, then IDLE for one cycle. Throughput is one operation per STEPS+2 cycles.
- out_valid and the outputs are registered. in_ready is decoded from state only, with no combinational path from in_valid or out_ready.
- Backpressure: while out_valid && !out_ready, all outputs are stable and in_ready=0.

## Test plan
All scenarios use WIDTH=16, DIGIT=4 unless noted.
- 0x1234 - 0x0234, cin=0 → difference=0x1000, borrow_out=0, overflow=0. out_valid is high exactly 4 cycles after the accept edge.
- 0x0000 - 0x0001, cin=0 → 0xFFFF, borrow_out=1, overflow=0. This covers borrow ripple through all 4 slices. Also 0x0005 - 0x0005, cin=1 → 0xFFFF, borrow_out=1.
- Overflow cases:
  - 0x8000 - 0x0001 → 0x7FFF, borrow_out=0, overflow=1.
  - 0x7FFF - 0xFFFF → 0x8000, borrow_out=1, overflow=1.
  - 0x7FFF - 0x0001 → 0x7FFE, overflow=0.
- WIDTH=1, DIGIT=1 instance: sweep all 8 (minuend, subtrahend, carry_in) combinations in binary order. Required {borrow_out, difference} = 00,11,11,10,01,00,00,11. Each result arrives 1 cycle after accept.
- Backpressure:
  - Hold out_ready=0 for 5 cycles after out_valid. Outputs stay stable, in_ready=0, and an in_valid pulse with 0xFFFF - 0x0001 is ignored.
  - Raise out_ready: the next cycle is IDLE with in_ready=1. A subsequent 0xFFFF - 0x0001 returns 0xFFFE.
- Reset mid-operation:
  - Assert rst after 2 RUN cycles. out_valid=0, in_ready=1 and difference=0 take effect immediately, without waiting for a clock edge.
  - Release rst and run 0x00FF - 0x0F00 → 0xF1FF, borrow_out=1, overflow=0.
